vfd_freq_ramp_ctrl: RTL and testbench
=====================================

// Module: vfd_freq_ramp_ctrl
// PURPOSE
//   Soft-start/soft-stop frequency controller for the VFD switching clock.
//   Holds a programmable half-period divider and slews its half-period count
//   from a stopped/slow value toward a commanded target at a bounded rate.
//   Output clk_out feeds the PWM/phase sequencer in place of a fixed divider.
// PARAMETERS
//   CNT_W     13    width of half-period count and divider counter
//   MAX_HALF  4095  slowest half-period count (start/stop point), <= 2**CNT_W-1
//   MIN_HALF  16    fastest half-period count allowed
//   RAMP_STEP 16    half-period change per ramp update
//   RAMP_DIV  1000  clk_in cycles between ramp updates (>=1)
// PORTS
//   clk_in       in   1      system clock
//   reset        in   1      asynchronous, active-high reset
//   enable       in   1      run request; level-sensitive
//   target_half  in   CNT_W  commanded half-period count
//   target_load  in   1      1-cycle strobe: latch target_half
//   clk_out      out  1      divided VFD clock, 50% duty at cur_half
//   cur_half     out  CNT_W  half-period currently applied
//   state        out  2      0 IDLE, 1 RAMP, 2 RUN, 3 STOP
//   at_speed     out  1      1 when state==RUN
// BEHAVIOUR
//   Reset: clk_out=0, cur_half=MAX_HALF, tgt=MAX_HALF, div/ramp counters=0,
//     state=IDLE, at_speed=0. Reset mid-operation aborts instantly, no ramp.
//   Target latch: on target_load, tgt <= clamp(target_half, MIN_HALF, MAX_HALF);
//     accepted in any state; takes effect at next ramp update.
//   Divider: active in RAMP/RUN/STOP. div_cnt counts up; when
//     div_cnt >= cur_half: div_cnt<=0, clk_out toggles. '>=' guarantees no
//     wrap when cur_half shrinks below div_cnt. In IDLE div_cnt=0, clk_out=0.
//   Ramp tick: ramp_cnt counts 0..RAMP_DIV-1 in RAMP/STOP; tick on terminal
//     value, then ramp_cnt<=0. ramp_cnt cleared on entering RAMP or STOP.
//   Slew on tick: goal = tgt (RAMP) or MAX_HALF (STOP);
//     cur_half>goal: cur_half <= max(cur_half-RAMP_STEP, goal);
//     cur_half<goal: cur_half <= min(cur_half+RAMP_STEP, goal). Never overshoot;
//     arithmetic done in CNT_W+1 bits to avoid underflow/overflow.
//   FSM (one transition per cycle):
//     IDLE: enable=1 -> RAMP.
//     RAMP: enable=0 -> STOP; else cur_half==tgt -> RUN.
//     RUN : enable=0 -> STOP; else tgt!=cur_half -> RAMP.
//     STOP: enable=1 -> RAMP (resume from current cur_half);
//           cur_half==MAX_HALF and clk_out toggles 1->0 this cycle -> IDLE.
//   STOP->IDLE only on a falling clk_out edge so last output pulse is complete.
//   Simultaneous target_load and RAMP->RUN: new tgt wins next cycle (RUN->RAMP).
//   at_speed registered with state; cur_half/state are registered outputs.
// TESTING (bench: MAX_HALF=1000, MIN_HALF=10, RAMP_STEP=100, RAMP_DIV=4)
//   Reset asserted mid-RUN -> same cycle clk_out=0, cur_half=1000, state=0.
//   Load 500, enable=1 -> RAMP; cur_half 900,800,700,600,500 every 4 cycles;
//     state=RUN, at_speed=1 the cycle after cur_half==500; half-period 501 clks.
//   Load 5 -> tgt clamps to 10; load 1950 -> tgt clamps to 1000.
//   RUN at 500, load 450 -> RAMP; next tick cur_half=450 (no overshoot to 400).
//   RUN at 500, enable=0 -> STOP; 500->1000 in 5 ticks; IDLE on next
//     clk_out fall; clk_out stays 0 afterwards.
//   During STOP at 800, enable=1 -> RAMP; cur_half returns toward 500, no jump.

Source files
------------

// File: rtl/vfd_freq_ramp_ctrl.sv
// vfd_freq_ramp_ctrl: soft-start/soft-stop half-period divider for the VFD switching clock
module vfd_freq_ramp_ctrl #(
  parameter int CNT_W     = 13,
  parameter int MAX_HALF  = 4095,
  parameter int MIN_HALF  = 16,
  parameter int RAMP_STEP = 16,
  parameter int RAMP_DIV  = 1000
) (
  input  logic             i_clk_in,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_target_half,
  input  logic             i_target_load,
  output logic             o_clk_out,
  output logic [CNT_W-1:0] o_cur_half,
  output logic [1:0]       o_state,
  output logic             o_at_speed
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RAMP = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] STOP = 2'd3;
  localparam logic [CNT_W-1:0] MAX_H = CNT_W'(MAX_HALF);
  localparam logic [CNT_W-1:0] MIN_H = CNT_W'(MIN_HALF);
  localparam logic [CNT_W:0] STEP = (CNT_W+1)'(RAMP_STEP);
  localparam int RC_W = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  localparam logic [RC_W-1:0] RC_END = RC_W'(RAMP_DIV - 1);

  logic             r_clk_out;
  logic [CNT_W-1:0] r_cur_half;
  logic [CNT_W-1:0] r_tgt;
  logic [CNT_W-1:0] r_div_cnt;
  logic [RC_W-1:0]  r_ramp_cnt;
  logic [1:0]       r_state;
  logic             r_at_speed;

  logic             w_run;
  logic             w_slew;
  logic             w_hit;
  logic             w_tick;
  logic             w_enter;
  logic [CNT_W-1:0] w_goal;
  logic [CNT_W:0]   w_dn;
  logic [CNT_W:0]   w_up;
  logic [CNT_W-1:0] w_slewed;
  logic [CNT_W-1:0] w_tgt_clamp;
  logic [1:0]       w_nxt;

  assign w_run  = r_state != IDLE;
  assign w_slew = r_state == RAMP || r_state == STOP;
  // '>=' lets the divider terminate immediately if cur_half shrank below the count
  assign w_hit  = r_div_cnt >= r_cur_half;
  assign w_tick = w_slew && r_ramp_cnt == RC_END;
  assign w_goal = r_state == STOP ? MAX_H : r_tgt;
  assign w_dn   = {1'b0, r_cur_half} - STEP;
  assign w_up   = {1'b0, r_cur_half} + STEP;
  // Extra bit catches underflow/overflow so the step clips to the goal instead of wrapping
  assign w_slewed = r_cur_half > w_goal
    ? (({1'b0, r_cur_half} < STEP || w_dn < {1'b0, w_goal}) ? w_goal : w_dn[CNT_W-1:0])
    : r_cur_half < w_goal
    ? (w_up > {1'b0, w_goal} ? w_goal : w_up[CNT_W-1:0])
    : r_cur_half;
  assign w_tgt_clamp = i_target_half < MIN_H ? MIN_H
                     : i_target_half > MAX_H ? MAX_H : i_target_half;

  always_comb begin
    w_nxt = r_state == IDLE ? (i_enable ? RAMP : IDLE)
          : r_state == RAMP ? (!i_enable ? STOP : r_cur_half == r_tgt ? RUN : RAMP)
          : r_state == RUN  ? (!i_enable ? STOP : r_tgt != r_cur_half ? RAMP : RUN)
          : (i_enable ? RAMP : (r_cur_half == MAX_H && w_hit && r_clk_out) ? IDLE : STOP);
  end

  assign w_enter = (w_nxt == RAMP || w_nxt == STOP) && w_nxt != r_state;

  always_ff @(posedge i_clk_in or posedge i_reset) begin
    if (i_reset) begin
      r_clk_out  <= 1'b0;
      r_cur_half <= MAX_H;
      r_tgt      <= MAX_H;
      r_div_cnt  <= '0;
      r_ramp_cnt <= '0;
      r_state    <= IDLE;
      r_at_speed <= 1'b0;
    end else begin
      if (i_target_load) r_tgt <= w_tgt_clamp;
      r_state    <= w_nxt;
      r_at_speed <= w_nxt == RUN;
      r_div_cnt  <= (!w_run || w_hit) ? '0 : r_div_cnt + 1'b1;
      r_clk_out  <= w_run && (r_clk_out ^ w_hit);
      r_ramp_cnt <= (w_enter || !w_slew || w_tick) ? '0 : r_ramp_cnt + 1'b1;
      if (w_tick) r_cur_half <= w_slewed;
    end
  end

  assign o_clk_out  = r_clk_out;
  assign o_cur_half = r_cur_half;
  assign o_state    = r_state;
  assign o_at_speed = r_at_speed;
endmodule

// File: tb/tb_vfd_freq_ramp_ctrl.sv
// tb_vfd_freq_ramp_ctrl: directed self-checking bench for the VFD frequency ramp controller
module tb_vfd_freq_ramp_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [12:0] th;
  logic        clko;
  logic [12:0] cur;
  logic [1:0]  st;
  logic        at;
  int checks = 0;
  int errors = 0;

  vfd_freq_ramp_ctrl #(
    .CNT_W(13), .MAX_HALF(1000), .MIN_HALF(10), .RAMP_STEP(100), .RAMP_DIV(4)
  ) dut (
    .i_clk_in(clk), .i_reset(rst), .i_enable(en), .i_target_half(th),
    .i_target_load(load), .o_clk_out(clko), .o_cur_half(cur), .o_state(st),
    .o_at_speed(at)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [12:0] v);
    th = v;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int lim, input string tag);
    int k;
    k = 0;
    while (st !== s && k < lim) begin
      cyc(1);
      k++;
    end
    chk(tag, 32'(st), 32'(s));
  endtask

  task automatic wait_chg(input int lim, input string tag, input logic [31:0] exp);
    logic [12:0] p;
    int k;
    p = cur;
    k = 0;
    while (cur === p && k < lim) begin
      cyc(1);
      k++;
    end
    chk(tag, 32'(cur), exp);
  endtask

  task automatic wait_toggle(input int lim, output int n);
    logic p;
    p = clko;
    n = 0;
    while (clko === p && n < lim) begin
      cyc(1);
      n++;
    end
  endtask

  initial begin
    int seq_up[5];
    int seq_dn[5];
    int n;
    int ones;
    int k;
    logic pc;
    seq_dn = '{900, 800, 700, 600, 500};
    seq_up = '{600, 700, 800, 900, 1000};
    rst = 1'b1; en = 1'b0; load = 1'b0; th = '0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("rst_state", 32'(st), 0);
    chk("rst_cur", 32'(cur), 1000);
    chk("rst_clk", 32'(clko), 0);
    chk("rst_at_speed", 32'(at), 0);
    cyc(5);
    chk("idle_hold_clk", 32'(clko), 0);

    th = 13'd500; load = 1'b1; en = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("ramp_entry", 32'(st), 1);
    chk("ramp_at_speed", 32'(at), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(4);
      chk("ramp_step", 32'(cur), 32'(seq_dn[i]));
    end
    chk("pre_run_state", 32'(st), 1);
    cyc(1);
    chk("run_state", 32'(st), 2);
    chk("run_at_speed", 32'(at), 1);
    wait_toggle(1100, n);
    wait_toggle(1100, n);
    chk("half_period", 32'(n), 501);

    do_load(13'd450);
    cyc(1);
    chk("retarget_ramp", 32'(st), 1);
    wait_chg(20, "no_overshoot", 450);
    wait_state(2, 10, "run_450");
    do_load(13'd500);
    wait_chg(20, "back_500", 500);
    wait_state(2, 10, "run_500");

    en = 1'b0;
    cyc(1);
    chk("stop_entry", 32'(st), 3);
    for (int i = 0; i < 5; i++) wait_chg(20, "stop_step", 32'(seq_up[i]));
    k = 0;
    pc = clko;
    while (st !== 2'd0 && k < 3000) begin
      pc = clko;
      cyc(1);
      k++;
    end
    chk("stop_idle", 32'(st), 0);
    chk("idle_prev_clk_high", 32'(pc), 1);
    chk("idle_clk_low", 32'(clko), 0);
    ones = 0;
    repeat (50) begin
      cyc(1);
      if (clko !== 1'b0) ones++;
    end
    chk("idle_clk_quiet", 32'(ones), 0);

    en = 1'b1;
    wait_state(2, 200, "rerun_500");
    chk("rerun_cur", 32'(cur), 500);
    en = 1'b0;
    cyc(1);
    chk("stop2_entry", 32'(st), 3);
    wait_chg(20, "stop2_600", 600);
    wait_chg(20, "stop2_700", 700);
    wait_chg(20, "stop2_800", 800);
    en = 1'b1;
    cyc(1);
    chk("resume_state", 32'(st), 1);
    chk("resume_no_jump", 32'(cur), 800);
    wait_chg(20, "resume_step", 700);
    wait_state(2, 100, "resume_run");
    chk("resume_cur", 32'(cur), 500);

    do_load(13'd5);
    cyc(1);
    chk("clamp_lo_ramp", 32'(st), 1);
    wait_state(2, 200, "clamp_lo_run");
    chk("clamp_lo_cur", 32'(cur), 10);
    do_load(13'd1950);
    cyc(1);
    wait_chg(20, "clamp_hi_first", 110);
    wait_state(2, 200, "clamp_hi_run");
    chk("clamp_hi_cur", 32'(cur), 1000);

    k = 0;
    while (clko !== 1'b1 && k < 2100) begin
      cyc(1);
      k++;
    end
    chk("pre_reset_clk", 32'(clko), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(st), 0);
    chk("async_rst_cur", 32'(cur), 1000);
    chk("async_rst_clk", 32'(clko), 0);
    chk("async_rst_at", 32'(at), 0);
    cyc(2);
    rst = 1'b0;
    cyc(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
